// File: rtl/cpu_sequencer.sv
// cpu_sequencer: multi-cycle fetch/decode/execute controller for the 8-bit CPU.
// Owns the program counter, fetches instruction bytes through a ready
// handshake, and drives ALU selects plus one-hot register save strobes.
module cpu_sequencer #(
  parameter logic [7:0] PC_RESET   = 8'h00,
  parameter int         WAIT_LIMIT = 15
) (
  input  logic       clk,
  input  logic       reset,
  output logic [7:0] mem_addr,
  output logic       mem_rd,
  input  logic [7:0] mem_data,
  input  logic       mem_ready,
  output logic [2:0] alu_op,
  output logic [1:0] src_sel,
  output logic [1:0] dst_sel,
  output logic [7:0] imm_data,
  output logic       wb_sel,
  output logic [3:0] reg_save,
  output logic       reg_reset,
  output logic       halted,
  output logic       fault
);

  localparam logic [2:0] OP_NOP = 3'b000;
  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_SUB = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_OR  = 3'b100;
  localparam logic [2:0] OP_LDI = 3'b101;
  localparam logic [2:0] OP_JMP = 3'b110;
  localparam logic [2:0] OP_HLT = 3'b111;

  // Wait counter value at which one more idle cycle means a timeout.
  localparam logic [7:0] WAIT_LAST = 8'(WAIT_LIMIT - 1);

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_IMM    = 3'd2,
    ST_EXEC   = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5
  } state_t;

  state_t     state_r, state_s;
  logic [7:0] pc_r, pc_s;
  logic [7:0] ir_r, ir_s;
  logic [7:0] imm_r, imm_s;
  logic [7:0] wait_cnt_r, wait_cnt_s;
  logic       fault_r, fault_s;
  logic       reset_seen_r;

  logic [2:0] opcode_s;
  logic       ir_spare_unused_s;

  // Map an opcode to the ALU function code; non-ALU opcodes give 000.
  function automatic logic [2:0] alu_code(input logic [2:0] op);
    logic [2:0] code;
    case (op)
      OP_ADD:  code = 3'b001;
      OP_SUB:  code = 3'b010;
      OP_AND:  code = 3'b011;
      OP_OR:   code = 3'b100;
      default: code = 3'b000;
    endcase
    return code;
  endfunction

  // One-hot save strobe for register index A..D.
  function automatic logic [3:0] save_onehot(input logic [1:0] idx);
    logic [3:0] oh;
    case (idx)
      2'd0:    oh = 4'b0001;
      2'd1:    oh = 4'b0010;
      2'd2:    oh = 4'b0100;
      2'd3:    oh = 4'b1000;
      default: oh = 4'b0000;
    endcase
    return oh;
  endfunction

  assign opcode_s          = ir_r[7:5];
  assign ir_spare_unused_s = ir_r[0];

  // Next-state, PC, instruction/immediate latching and memory wait timeout.
  always_comb begin
    state_s    = state_r;
    pc_s       = pc_r;
    ir_s       = ir_r;
    imm_s      = imm_r;
    wait_cnt_s = 8'd0;
    fault_s    = fault_r;
    case (state_r)
      ST_FETCH: begin
        if (mem_ready) begin
          ir_s    = mem_data;
          pc_s    = pc_r + 8'd1;
          state_s = ST_DECODE;
        end else if (wait_cnt_r == WAIT_LAST) begin
          fault_s = 1'b1;
          state_s = ST_HALT;
        end else begin
          wait_cnt_s = wait_cnt_r + 8'd1;
        end
      end
      ST_DECODE: begin
        case (opcode_s)
          OP_NOP:                       state_s = ST_FETCH;
          OP_ADD, OP_SUB, OP_AND, OP_OR: state_s = ST_EXEC;
          OP_LDI, OP_JMP:               state_s = ST_IMM;
          OP_HLT:                       state_s = ST_HALT;
          default:                      state_s = ST_FETCH;
        endcase
      end
      ST_IMM: begin
        if (mem_ready) begin
          if (opcode_s == OP_LDI) begin
            imm_s   = mem_data;
            pc_s    = pc_r + 8'd1;
            state_s = ST_WB;
          end else begin
            // JMP: the operand byte is the new PC, no increment.
            pc_s    = mem_data;
            state_s = ST_FETCH;
          end
        end else if (wait_cnt_r == WAIT_LAST) begin
          fault_s = 1'b1;
          state_s = ST_HALT;
        end else begin
          wait_cnt_s = wait_cnt_r + 8'd1;
        end
      end
      ST_EXEC: state_s = ST_WB;
      ST_WB:   state_s = ST_FETCH;
      ST_HALT: state_s = ST_HALT;
      default: state_s = ST_FETCH;
    endcase
  end

  // Sequencer state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= ST_FETCH;
      pc_r       <= PC_RESET;
      ir_r       <= 8'h00;
      imm_r      <= 8'h00;
      wait_cnt_r <= 8'd0;
      fault_r    <= 1'b0;
    end else begin
      state_r    <= state_s;
      pc_r       <= pc_s;
      ir_r       <= ir_s;
      imm_r      <= imm_s;
      wait_cnt_r <= wait_cnt_s;
      fault_r    <= fault_s;
    end
  end

  // Remember that reset was sampled so registers get a one-cycle clear strobe.
  always_ff @(posedge clk) begin
    reset_seen_r <= reset;
  end

  // Strobe decode; everything is forced quiet while reset is asserted so an
  // aborted instruction can never issue a save.
  always_comb begin
    mem_rd   = 1'b0;
    alu_op   = 3'b000;
    wb_sel   = 1'b0;
    reg_save = 4'b0000;
    if (reset) begin
      mem_rd   = 1'b0;
      reg_save = 4'b0000;
    end else begin
      case (state_r)
        ST_FETCH, ST_IMM: mem_rd = 1'b1;
        ST_EXEC:          alu_op = alu_code(opcode_s);
        ST_WB: begin
          alu_op   = alu_code(opcode_s);
          reg_save = save_onehot(ir_r[4:3]);
          wb_sel   = (opcode_s == OP_LDI);
        end
        default: begin
          mem_rd   = 1'b0;
          reg_save = 4'b0000;
        end
      endcase
    end
  end

  assign mem_addr  = pc_r;
  assign src_sel   = ir_r[2:1];
  assign dst_sel   = ir_r[4:3];
  assign imm_data  = imm_r;
  assign reg_reset = reset_seen_r;
  assign halted    = (state_r == ST_HALT);
  assign fault     = fault_r;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Self-checking bench for cpu_sequencer: a per-cycle vector table, directed
// multi-cycle corner cases, and randomized programs checked against an
// instruction-level model of the CPU.
module tb_cpu_sequencer;

  localparam int WL = 4;

  logic       clk;
  logic       reset;
  logic [7:0] mem_addr;
  logic       mem_rd;
  logic [7:0] mem_data;
  logic       mem_ready;
  logic [2:0] alu_op;
  logic [1:0] src_sel;
  logic [1:0] dst_sel;
  logic [7:0] imm_data;
  logic       wb_sel;
  logic [3:0] reg_save;
  logic       reg_reset;
  logic       halted;
  logic       fault;

  logic [7:0] mem [0:255];
  int n_cmp;
  int n_bad;

  assign mem_data = mem[mem_addr];

  cpu_sequencer #(.PC_RESET(8'h00), .WAIT_LIMIT(WL)) dut (
    .clk(clk), .reset(reset), .mem_addr(mem_addr), .mem_rd(mem_rd),
    .mem_data(mem_data), .mem_ready(mem_ready), .alu_op(alu_op),
    .src_sel(src_sel), .dst_sel(dst_sel), .imm_data(imm_data),
    .wb_sel(wb_sel), .reg_save(reg_save), .reg_reset(reg_reset),
    .halted(halted), .fault(fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rdy;
    logic       rd;
    logic [7:0] addr;
    logic [2:0] alu;
    logic       sel_chk;
    logic [1:0] dst;
    logic [1:0] src;
    logic       wb;
    logic [3:0] save;
    logic [7:0] imm;
    logic       halt;
    logic       rr;
  } vec_t;

  function automatic vec_t mk(input logic rdy, input logic rd, input logic [7:0] addr,
                              input logic [2:0] alu, input logic sel_chk,
                              input logic [1:0] dst, input logic [1:0] src,
                              input logic wb, input logic [3:0] save,
                              input logic [7:0] imm, input logic halt, input logic rr);
    vec_t v;
    v.rdy = rdy; v.rd = rd; v.addr = addr; v.alu = alu; v.sel_chk = sel_chk;
    v.dst = dst; v.src = src; v.wb = wb; v.save = save; v.imm = imm;
    v.halt = halt; v.rr = rr;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Advance one clock: through the active edge to the following falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
  endtask

  function automatic logic [19:0] wr_pack(input logic [3:0] save, input logic wb,
                                          input logic [2:0] alu, input logic [1:0] dst,
                                          input logic [1:0] src, input logic [7:0] imm);
    return {save, wb, alu, dst, src, imm};
  endfunction

  // Randomized program run: an architectural interpreter predicts the memory
  // reads, register writes, total cycle count and final status; the DUT is
  // run for exactly that many cycles with a stalling memory responder.
  task automatic run_random();
    logic [7:0]  pc;
    logic [7:0]  ins;
    logic [2:0]  op;
    logic [3:0]  oh;
    int          cyc;
    int          ri;
    int          r;
    bit          stop;
    bit          exp_halt;
    bit          exp_fault;
    int          stall [128];
    int          low_cnt;
    int          rd_i;
    logic [7:0]  exp_rd [$];
    logic [7:0]  act_rd [$];
    logic [19:0] exp_wr [$];
    logic [19:0] act_wr [$];

    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    for (int i = 0; i < 128; i++) begin
      r = $urandom_range(0, 39);
      if (r < 27)      stall[i] = 0;
      else if (r < 37) stall[i] = 1 + (r % 3);
      else if (r < 39) stall[i] = WL - 1;
      else             stall[i] = WL + $urandom_range(0, 3);
    end

    pc = 8'h00; cyc = 0; ri = 0; stop = 0; exp_halt = 0; exp_fault = 0;
    for (int n = 0; n < 30 && !stop; n++) begin
      if (stall[ri] >= WL) begin
        cyc += WL; exp_fault = 1; exp_halt = 1; stop = 1;
      end else begin
        cyc += stall[ri] + 1; exp_rd.push_back(pc); ri++;
        ins = mem[pc]; pc = pc + 8'd1; op = ins[7:5];
        oh = 4'b0001 << ins[4:3];
        cyc += 1;
        case (op)
          3'd1, 3'd2, 3'd3, 3'd4: begin
            cyc += 2;
            exp_wr.push_back(wr_pack(oh, 1'b0, op, ins[4:3], ins[2:1], 8'h00));
          end
          3'd5, 3'd6: begin
            if (stall[ri] >= WL) begin
              cyc += WL; exp_fault = 1; exp_halt = 1; stop = 1;
            end else begin
              cyc += stall[ri] + 1; exp_rd.push_back(pc); ri++;
              if (op == 3'd5) begin
                exp_wr.push_back(wr_pack(oh, 1'b1, 3'b000, ins[4:3], ins[2:1], mem[pc]));
                pc = pc + 8'd1;
                cyc += 1;
              end else begin
                pc = mem[pc];
              end
            end
          end
          3'd7: begin
            exp_halt = 1; stop = 1;
          end
          default: ;
        endcase
      end
    end

    mem_ready = 1'b1;
    do_reset();
    rd_i = 0; low_cnt = 0;
    for (int c = 0; c < cyc; c++) begin
      if (reg_save !== 4'b0000)
        act_wr.push_back(wr_pack(reg_save, wb_sel, alu_op, dst_sel, src_sel,
                                 wb_sel ? imm_data : 8'h00));
      if (mem_rd === 1'b1 && rd_i < 128) begin
        if (low_cnt < stall[rd_i]) begin
          mem_ready = 1'b0; low_cnt++;
        end else begin
          mem_ready = 1'b1; act_rd.push_back(mem_addr); rd_i++; low_cnt = 0;
        end
      end else begin
        mem_ready = 1'($urandom_range(0, 1));
      end
      step();
    end

    chk("rand_halted", 32'(halted), 32'(exp_halt));
    chk("rand_fault", 32'(fault), 32'(exp_fault));
    if (exp_halt) begin
      chk("rand_halt_rd", 32'(mem_rd), 32'd0);
    end else begin
      chk("rand_next_rd", 32'(mem_rd), 32'd1);
      chk("rand_next_addr", 32'(mem_addr), 32'(pc));
    end
    chk("rand_rd_count", 32'(act_rd.size()), 32'(exp_rd.size()));
    for (int i = 0; i < exp_rd.size() && i < act_rd.size(); i++)
      chk($sformatf("rand_rd_addr%0d", i), 32'(act_rd[i]), 32'(exp_rd[i]));
    chk("rand_wr_count", 32'(act_wr.size()), 32'(exp_wr.size()));
    for (int i = 0; i < exp_wr.size() && i < act_wr.size(); i++)
      chk($sformatf("rand_wr%0d", i), 32'(act_wr[i]), 32'(exp_wr[i]));
  endtask

  // Guard against a hung run.
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t tbl [15];
    n_cmp = 0;
    n_bad = 0;
    reset = 1'b1;
    mem_ready = 1'b0;

    // LDI A,#5A ; ADD B,A ; HLT with a 3-cycle stall on the first fetch
    // (the last stall cycle sits exactly at the timeout boundary).
    //            rdy  rd   addr   alu     chk  dst    src    wb   save     imm    hlt  rr
    tbl[0]  = mk(1'b0, 1'b1, 8'h00, 3'b000, 1'b0, 2'd0, 2'd0, 1'b0, 4'b0000, 8'h00, 1'b0, 1'b1);
    tbl[1]  = mk(1'b0, 1'b1, 8'h00, 3'b000, 1'b0, 2'd0, 2'd0, 1'b0, 4'b0000, 8'h00, 1'b0, 1'b0);
    tbl[2]  = mk(1'b0, 1'b1, 8'h00, 3'b000, 1'b0, 2'd0, 2'd0, 1'b0, 4'b0000, 8'h00, 1'b0, 1'b0);
    tbl[3]  = mk(1'b1, 1'b1, 8'h00, 3'b000, 1'b0, 2'd0, 2'd0, 1'b0, 4'b0000, 8'h00, 1'b0, 1'b0);
    tbl[4]  = mk(1'b0, 1'b0, 8'h01, 3'b000, 1'b0, 2'd0, 2'd0, 1'b0, 4'b0000, 8'h00, 1'b0, 1'b0);
    tbl[5]  = mk(1'b1, 1'b1, 8'h01, 3'b000, 1'b0, 2'd0, 2'd0, 1'b0, 4'b0000, 8'h00, 1'b0, 1'b0);
    tbl[6]  = mk(1'b1, 1'b0, 8'h02, 3'b000, 1'b1, 2'd0, 2'd0, 1'b1, 4'b0001, 8'h5A, 1'b0, 1'b0);
    tbl[7]  = mk(1'b1, 1'b1, 8'h02, 3'b000, 1'b0, 2'd0, 2'd0, 1'b0, 4'b0000, 8'h5A, 1'b0, 1'b0);
    tbl[8]  = mk(1'b1, 1'b0, 8'h03, 3'b000, 1'b0, 2'd0, 2'd0, 1'b0, 4'b0000, 8'h5A, 1'b0, 1'b0);
    tbl[9]  = mk(1'b1, 1'b0, 8'h03, 3'b001, 1'b1, 2'd1, 2'd0, 1'b0, 4'b0000, 8'h5A, 1'b0, 1'b0);
    tbl[10] = mk(1'b0, 1'b0, 8'h03, 3'b001, 1'b1, 2'd1, 2'd0, 1'b0, 4'b0010, 8'h5A, 1'b0, 1'b0);
    tbl[11] = mk(1'b1, 1'b1, 8'h03, 3'b000, 1'b0, 2'd0, 2'd0, 1'b0, 4'b0000, 8'h5A, 1'b0, 1'b0);
    tbl[12] = mk(1'b1, 1'b0, 8'h04, 3'b000, 1'b0, 2'd0, 2'd0, 1'b0, 4'b0000, 8'h5A, 1'b0, 1'b0);
    tbl[13] = mk(1'b1, 1'b0, 8'h04, 3'b000, 1'b0, 2'd0, 2'd0, 1'b0, 4'b0000, 8'h5A, 1'b1, 1'b0);
    tbl[14] = mk(1'b0, 1'b0, 8'h04, 3'b000, 1'b0, 2'd0, 2'd0, 1'b0, 4'b0000, 8'h5A, 1'b1, 1'b0);

    // NOP ; HLT with memory always ready.
    clear_mem();
    mem[8'h00] = 8'h00; mem[8'h01] = 8'hE0;
    mem_ready = 1'b1;
    do_reset();
    chk("nop_c0_reg_reset", 32'(reg_reset), 32'd1);
    chk("nop_c0_rd", 32'(mem_rd), 32'd1);
    chk("nop_c0_addr", 32'(mem_addr), 32'h00);
    chk("nop_c0_save", 32'(reg_save), 32'h0);
    chk("nop_c0_fault", 32'(fault), 32'd0);
    step();
    chk("nop_c1_reg_reset", 32'(reg_reset), 32'd0);
    chk("nop_c1_rd", 32'(mem_rd), 32'd0);
    step();
    chk("nop_c2_rd", 32'(mem_rd), 32'd1);
    chk("nop_c2_addr", 32'(mem_addr), 32'h01);
    step();
    chk("nop_c3_halted", 32'(halted), 32'd0);
    step();
    chk("nop_c4_halted", 32'(halted), 32'd1);
    chk("nop_c4_rd", 32'(mem_rd), 32'd0);

    // Table-driven LDI / ADD / HLT sequence.
    clear_mem();
    mem[8'h00] = 8'hA0; mem[8'h01] = 8'h5A; mem[8'h02] = 8'h28; mem[8'h03] = 8'hE0;
    mem_ready = 1'b0;
    do_reset();
    for (int i = 0; i < 15; i++) begin
      mem_ready = tbl[i].rdy;
      #1;
      chk($sformatf("tbl%0d_rd", i), 32'(mem_rd), 32'(tbl[i].rd));
      chk($sformatf("tbl%0d_addr", i), 32'(mem_addr), 32'(tbl[i].addr));
      chk($sformatf("tbl%0d_alu", i), 32'(alu_op), 32'(tbl[i].alu));
      chk($sformatf("tbl%0d_save", i), 32'(reg_save), 32'(tbl[i].save));
      chk($sformatf("tbl%0d_imm", i), 32'(imm_data), 32'(tbl[i].imm));
      chk($sformatf("tbl%0d_halted", i), 32'(halted), 32'(tbl[i].halt));
      chk($sformatf("tbl%0d_reg_reset", i), 32'(reg_reset), 32'(tbl[i].rr));
      chk($sformatf("tbl%0d_fault", i), 32'(fault), 32'd0);
      if (tbl[i].sel_chk) begin
        chk($sformatf("tbl%0d_dst", i), 32'(dst_sel), 32'(tbl[i].dst));
        chk($sformatf("tbl%0d_src", i), 32'(src_sel), 32'(tbl[i].src));
        chk($sformatf("tbl%0d_wb", i), 32'(wb_sel), 32'(tbl[i].wb));
      end
      step();
    end

    // JMP #FF, NOP at FF, PC wraps to 00. Location 00 is rewritten to HLT
    // once the JMP opcode has been fetched from it.
    clear_mem();
    mem[8'h00] = 8'hC0; mem[8'h01] = 8'hFF; mem[8'hFF] = 8'h00;
    mem_ready = 1'b1;
    do_reset();
    chk("jmp_c0_addr", 32'(mem_addr), 32'h00);
    step();
    mem[8'h00] = 8'hE0;
    step();
    chk("jmp_c2_rd", 32'(mem_rd), 32'd1);
    chk("jmp_c2_addr", 32'(mem_addr), 32'h01);
    step();
    chk("jmp_c3_rd", 32'(mem_rd), 32'd1);
    chk("jmp_c3_addr", 32'(mem_addr), 32'hFF);
    step();
    chk("jmp_c4_addr_wrap", 32'(mem_addr), 32'h00);
    step();
    chk("jmp_c5_rd", 32'(mem_rd), 32'd1);
    chk("jmp_c5_addr", 32'(mem_addr), 32'h00);
    step();
    step();
    chk("jmp_c7_halted", 32'(halted), 32'd1);
    chk("jmp_c7_fault", 32'(fault), 32'd0);

    // Memory never ready: fault after WL idle fetch cycles, cleared by reset.
    clear_mem();
    mem_ready = 1'b0;
    do_reset();
    step(); step(); step();
    chk("to_c3_fault", 32'(fault), 32'd0);
    chk("to_c3_halted", 32'(halted), 32'd0);
    chk("to_c3_rd", 32'(mem_rd), 32'd1);
    step();
    chk("to_c4_fault", 32'(fault), 32'd1);
    chk("to_c4_halted", 32'(halted), 32'd1);
    chk("to_c4_rd", 32'(mem_rd), 32'd0);
    mem_ready = 1'b1;
    step();
    chk("to_c5_halted", 32'(halted), 32'd1);
    chk("to_c5_fault", 32'(fault), 32'd1);
    do_reset();
    chk("to_rst_fault", 32'(fault), 32'd0);
    chk("to_rst_halted", 32'(halted), 32'd0);

    // Reset asserted during EXEC of SUB B,B aborts it without a save.
    clear_mem();
    mem[8'h00] = 8'h4A; mem[8'h01] = 8'hE0;
    mem_ready = 1'b1;
    do_reset();
    step(); step();
    chk("sub_exec_alu", 32'(alu_op), 32'b010);
    reset = 1'b1;
    #1;
    chk("sub_rst_alu", 32'(alu_op), 32'b000);
    chk("sub_rst_save", 32'(reg_save), 32'h0);
    chk("sub_rst_rd", 32'(mem_rd), 32'd0);
    step();
    reset = 1'b0;
    #1;
    chk("sub_after_save", 32'(reg_save), 32'h0);
    chk("sub_after_addr", 32'(mem_addr), 32'h00);
    chk("sub_after_rd", 32'(mem_rd), 32'd1);
    chk("sub_after_reg_reset", 32'(reg_reset), 32'd1);
    step();
    chk("sub_after2_save", 32'(reg_save), 32'h0);

    // Randomized programs against the instruction-level model.
    for (int k = 0; k < 25; k++) run_random();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cpu_sequencer.md
Name: cpu_sequencer

Overview:
- Multi-cycle control FSM for the 8-bit CPU.
- Fetches instruction bytes from program memory through a ready handshake and decodes them.
- Drives ALU operation and operand selects, and issues one-hot save strobes to the four 8-bit datapath registers (A,B,C,D).
- Sits between program memory, the ALU and the register modules; owns the program counter.

Parameters:
- PC_RESET, 8'h00, program counter value loaded on reset.
- WAIT_LIMIT, 15, max cycles FETCH/IMM may wait for mem_ready before fault; range 1..255.

Ports:
- clk  in  1  system clock, all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- mem_addr  out  8  program memory address (current PC)
- mem_rd  out  1  memory read request, held until mem_ready
- mem_data  in  8  program memory read data, valid when mem_ready=1
- mem_ready  in  1  memory read completion for the current mem_rd
- alu_op  out  3  ALU function: 001 ADD, 010 SUB, 011 AND, 100 OR, else 000
- src_sel  out  2  register index for ALU operand B
- dst_sel  out  2  register index for ALU operand A and write target
- imm_data  out  8  immediate byte latched for LDI
- wb_sel  out  1  write-back source: 0 = ALU result, 1 = imm_data
- reg_save  out  4  one-hot save strobe to registers A..D, one-cycle pulse
- reg_reset  out  1  clear strobe to all registers
- halted  out  1  sequencer in HALT state
- fault  out  1  memory wait timeout occurred; sticky until reset

Behaviour:
- Instruction format: [7:5] opcode, [4:3] dst, [2:1] src, [0] ignored.
- Opcodes: 000 NOP, 001 ADD, 010 SUB, 011 AND, 100 OR, 101 LDI dst,#imm (2 bytes), 110 JMP #addr (2 bytes), 111 HLT.
- Reset (reset=1 at edge): pc=PC_RESET, state=FETCH, ir=0, imm_data=0, wait counter=0, fault=0.
  - All strobes (mem_rd, reg_save, alu_op) are 0 during reset cycles.
  - reg_reset=1 in each cycle following an edge where reset was sampled 1; otherwise 0.
- States: FETCH, DECODE, IMM, EXEC, WB, HALT.
- FETCH:
  - mem_rd=1, mem_addr=pc.
  - On mem_ready=1: ir<=mem_data, pc<=pc+1 (wraps 8'hFF->8'h00), go to DECODE.
- DECODE:
  - ALU ops -> EXEC.
  - LDI/JMP -> IMM.
  - NOP -> FETCH.
  - HLT -> HALT.
- IMM:
  - mem_rd=1, mem_addr=pc.
  - On mem_ready=1 with LDI: imm_data<=mem_data, pc<=pc+1, go to WB.
  - On mem_ready=1 with JMP: pc<=mem_data (no increment), go to FETCH.
- EXEC: alu_op, src_sel, dst_sel driven from ir; wb_sel=0; next WB.
- WB:
  - reg_save[dst]=1 for exactly this cycle; alu_op/src_sel/dst_sel held from EXEC.
  - wb_sel=1 for LDI, 0 otherwise; next FETCH.
- HALT: halted=1, no memory requests, no strobes; exits only via reset.
- Outputs outside the states listed above: alu_op=0, reg_save=0, mem_rd=0.
- Timeout:
  - The wait counter increments each FETCH/IMM cycle with mem_ready=0 and clears on state exit.
  - When it reaches WAIT_LIMIT with mem_ready still 0: fault<=1, go to HALT.
  - mem_ready on the same cycle the limit is reached counts as success.
- mem_ready is ignored outside FETCH/IMM.
- Latency with mem_ready tied high: NOP 2, ALU op 4, LDI 4, JMP 3 cycles.
- reset mid-instruction aborts it immediately; no reg_save is issued in the reset cycle or after.

Test Plan:
- Reset with PC_RESET=8'h00, mem_ready=1, program [8'h00 NOP, 8'hE0 HLT] -> addresses 00,01 fetched; halted=1 on the 4th cycle after reset release; reg_reset=1 only in the first cycle after reset.
- Program LDI A,#8'h5A (8'hA0,8'h5A) then ADD B,A (8'h28) -> reg_save=4'b0001 with wb_sel=1, imm_data=8'h5A; then 3 cycles later alu_op=001, dst_sel=1, src_sel=0, reg_save=4'b0010, wb_sel=0.
- JMP #8'hFF (8'hC0,8'hFF), 8'h00 at FF, 8'hE0 at 00 -> fetches FF then wraps to 00; halted=1.
- mem_ready held low 3 cycles on FETCH, WAIT_LIMIT=15 -> mem_rd and mem_addr stable throughout, instruction proceeds normally, fault=0.
- mem_ready held low permanently, WAIT_LIMIT=4 -> fault=1 and halted=1 after 4 wait cycles; both clear on reset.
- Assert reset during EXEC of SUB -> no reg_save pulse; pc=PC_RESET and state=FETCH on the next cycle.
